// File: rtl/axi_clint_xbar.sv
// ---------------------------------------------------------------------------
// axi_clint_xbar
//
// AXI4 1-to-2 address-decoding crossbar between the CPU memory-side master
// and two targets: the CLINT timer slave (M0) and the SoC interconnect (M1).
// Read and write paths are independent FSMs with one outstanding transaction
// each. Response IDs (RID/BID) are re-stamped from the latched request IDs,
// so a target that returns ID 0 (the CLINT does) stays ID-correct upstream.
//
// Ports:
//   clock, S_AXI_ARESETN       single clock, async active-low reset
//   S_AXI_AR*/R*/AW*/W*/B*     slave port facing the CPU
//   M0_AXI_*                   master port to the CLINT window
//   M1_AXI_*                   master port to the SoC (everything else)
//
// Address request channels add one cycle (registered); R, W and B are
// combinational pass-throughs to/from the selected port.
// ---------------------------------------------------------------------------
module axi_clint_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        S_AXI_ARESETN,

  // CPU side
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic [3:0]  S_AXI_RID,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic [3:0]  S_AXI_BID,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,

  // M0: CLINT
  output logic [31:0] M0_AXI_ARADDR,
  output logic [3:0]  M0_AXI_ARID,
  output logic [7:0]  M0_AXI_ARLEN,
  output logic [2:0]  M0_AXI_ARSIZE,
  output logic [1:0]  M0_AXI_ARBURST,
  output logic        M0_AXI_ARVALID,
  input  logic        M0_AXI_ARREADY,
  input  logic [31:0] M0_AXI_RDATA,
  input  logic [1:0]  M0_AXI_RRESP,
  input  logic [3:0]  M0_AXI_RID,
  input  logic        M0_AXI_RLAST,
  input  logic        M0_AXI_RVALID,
  output logic        M0_AXI_RREADY,
  output logic [31:0] M0_AXI_AWADDR,
  output logic [3:0]  M0_AXI_AWID,
  output logic [7:0]  M0_AXI_AWLEN,
  output logic [2:0]  M0_AXI_AWSIZE,
  output logic [1:0]  M0_AXI_AWBURST,
  output logic        M0_AXI_AWVALID,
  input  logic        M0_AXI_AWREADY,
  output logic [31:0] M0_AXI_WDATA,
  output logic [3:0]  M0_AXI_WSTRB,
  output logic        M0_AXI_WLAST,
  output logic        M0_AXI_WVALID,
  input  logic        M0_AXI_WREADY,
  input  logic [1:0]  M0_AXI_BRESP,
  input  logic [3:0]  M0_AXI_BID,
  input  logic        M0_AXI_BVALID,
  output logic        M0_AXI_BREADY,

  // M1: SoC interconnect
  output logic [31:0] M1_AXI_ARADDR,
  output logic [3:0]  M1_AXI_ARID,
  output logic [7:0]  M1_AXI_ARLEN,
  output logic [2:0]  M1_AXI_ARSIZE,
  output logic [1:0]  M1_AXI_ARBURST,
  output logic        M1_AXI_ARVALID,
  input  logic        M1_AXI_ARREADY,
  input  logic [31:0] M1_AXI_RDATA,
  input  logic [1:0]  M1_AXI_RRESP,
  input  logic [3:0]  M1_AXI_RID,
  input  logic        M1_AXI_RLAST,
  input  logic        M1_AXI_RVALID,
  output logic        M1_AXI_RREADY,
  output logic [31:0] M1_AXI_AWADDR,
  output logic [3:0]  M1_AXI_AWID,
  output logic [7:0]  M1_AXI_AWLEN,
  output logic [2:0]  M1_AXI_AWSIZE,
  output logic [1:0]  M1_AXI_AWBURST,
  output logic        M1_AXI_AWVALID,
  input  logic        M1_AXI_AWREADY,
  output logic [31:0] M1_AXI_WDATA,
  output logic [3:0]  M1_AXI_WSTRB,
  output logic        M1_AXI_WLAST,
  output logic        M1_AXI_WVALID,
  input  logic        M1_AXI_WREADY,
  input  logic [1:0]  M1_AXI_BRESP,
  input  logic [3:0]  M1_AXI_BID,
  input  logic        M1_AXI_BVALID,
  output logic        M1_AXI_BREADY
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP}  w_state_t;

  // Target response IDs are deliberately ignored: the latched request ID is
  // returned instead. Folded here so the inputs are visibly consumed.
  logic unused_target_ids;
  assign unused_target_ids = ^{M0_AXI_RID, M0_AXI_BID, M1_AXI_RID, M1_AXI_BID};

  // 1 selects M1 (SoC), 0 selects M0 (CLINT).
  function automatic logic sel_m1(input logic [31:0] addr);
    return (addr & CLINT_MASK) != CLINT_BASE;
  endfunction

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  r_state_t    r_state, r_state_nxt;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        rsel;
  logic        ar_hs;
  logic        sel_arready;

  assign ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
  assign sel_arready = rsel ? M1_AXI_ARREADY : M0_AXI_ARREADY;

  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched request fields are reset too; they are few and it keeps
  // the M-side payload deterministic out of reset.
  always_ff @(posedge clock or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= R_IDLE;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      rsel     <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        ar_addr  <= S_AXI_ARADDR;
        ar_id    <= S_AXI_ARID;
        ar_len   <= S_AXI_ARLEN;
        ar_size  <= S_AXI_ARSIZE;
        ar_burst <= S_AXI_ARBURST;
        rsel     <= sel_m1(S_AXI_ARADDR);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_nxt = R_ADDR;
      R_ADDR: if (sel_arready) r_state_nxt = R_DATA;
      R_DATA: if (S_AXI_RVALID & S_AXI_RREADY & S_AXI_RLAST) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY  = (r_state == R_IDLE);
    M0_AXI_ARVALID = 1'b0;
    M1_AXI_ARVALID = 1'b0;
    M0_AXI_RREADY  = 1'b0;
    M1_AXI_RREADY  = 1'b0;
    S_AXI_RVALID   = 1'b0;
    // Data/response payload always muxed from the selected port; only
    // meaningful while RVALID is high.
    S_AXI_RDATA    = rsel ? M1_AXI_RDATA : M0_AXI_RDATA;
    S_AXI_RRESP    = rsel ? M1_AXI_RRESP : M0_AXI_RRESP;
    S_AXI_RLAST    = rsel ? M1_AXI_RLAST : M0_AXI_RLAST;
    S_AXI_RID      = ar_id;
    case (r_state)
      R_ADDR: begin
        M0_AXI_ARVALID = ~rsel;
        M1_AXI_ARVALID = rsel;
      end
      R_DATA: begin
        S_AXI_RVALID  = rsel ? M1_AXI_RVALID : M0_AXI_RVALID;
        M0_AXI_RREADY = ~rsel & S_AXI_RREADY;
        M1_AXI_RREADY = rsel & S_AXI_RREADY;
      end
      default: ;
    endcase
  end

  // Both ports carry the latched AR payload; the VALID gating picks the target.
  assign M0_AXI_ARADDR  = ar_addr;
  assign M0_AXI_ARID    = ar_id;
  assign M0_AXI_ARLEN   = ar_len;
  assign M0_AXI_ARSIZE  = ar_size;
  assign M0_AXI_ARBURST = ar_burst;
  assign M1_AXI_ARADDR  = ar_addr;
  assign M1_AXI_ARID    = ar_id;
  assign M1_AXI_ARLEN   = ar_len;
  assign M1_AXI_ARSIZE  = ar_size;
  assign M1_AXI_ARBURST = ar_burst;

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  w_state_t    w_state, w_state_nxt;
  logic [31:0] aw_addr;
  logic [3:0]  aw_id;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        wsel;
  logic        aw_done;
  logic        w_done;
  logic        aw_hs;
  logic        m_aw_hs;
  logic        w_last_hs;
  logic        sel_awready;
  logic        sel_wready;

  assign aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
  assign sel_awready = wsel ? M1_AXI_AWREADY : M0_AXI_AWREADY;
  assign sel_wready  = wsel ? M1_AXI_WREADY : M0_AXI_WREADY;
  assign m_aw_hs     = (w_state == W_FWD) & ~aw_done & sel_awready;
  assign w_last_hs   = S_AXI_WVALID & S_AXI_WREADY & S_AXI_WLAST;

  always_ff @(posedge clock or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state  <= W_IDLE;
      aw_addr  <= '0;
      aw_id    <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      wsel     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        aw_addr  <= S_AXI_AWADDR;
        aw_id    <= S_AXI_AWID;
        aw_len   <= S_AXI_AWLEN;
        aw_size  <= S_AXI_AWSIZE;
        aw_burst <= S_AXI_AWBURST;
        wsel     <= sel_m1(S_AXI_AWADDR);
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        if (m_aw_hs)   aw_done <= 1'b1;
        if (w_last_hs) w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (aw_hs) w_state_nxt = W_FWD;
      // Count a completion that lands this cycle so AW and W finishing
      // together still exit immediately.
      W_FWD:  if ((aw_done | m_aw_hs) & (w_done | w_last_hs)) w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BVALID & S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY  = (w_state == W_IDLE);
    S_AXI_WREADY   = 1'b0;
    M0_AXI_AWVALID = 1'b0;
    M1_AXI_AWVALID = 1'b0;
    M0_AXI_WVALID  = 1'b0;
    M1_AXI_WVALID  = 1'b0;
    M0_AXI_BREADY  = 1'b0;
    M1_AXI_BREADY  = 1'b0;
    S_AXI_BVALID   = 1'b0;
    S_AXI_BRESP    = wsel ? M1_AXI_BRESP : M0_AXI_BRESP;
    S_AXI_BID      = aw_id;
    case (w_state)
      W_FWD: begin
        // AW and W are offered together; the CLINT needs both at once.
        M0_AXI_AWVALID = ~wsel & ~aw_done;
        M1_AXI_AWVALID = wsel & ~aw_done;
        M0_AXI_WVALID  = ~wsel & S_AXI_WVALID & ~w_done;
        M1_AXI_WVALID  = wsel & S_AXI_WVALID & ~w_done;
        S_AXI_WREADY   = sel_wready & ~w_done;
      end
      W_RESP: begin
        S_AXI_BVALID  = wsel ? M1_AXI_BVALID : M0_AXI_BVALID;
        M0_AXI_BREADY = ~wsel & S_AXI_BREADY;
        M1_AXI_BREADY = wsel & S_AXI_BREADY;
      end
      default: ;
    endcase
  end

  assign M0_AXI_AWADDR  = aw_addr;
  assign M0_AXI_AWID    = aw_id;
  assign M0_AXI_AWLEN   = aw_len;
  assign M0_AXI_AWSIZE  = aw_size;
  assign M0_AXI_AWBURST = aw_burst;
  assign M1_AXI_AWADDR  = aw_addr;
  assign M1_AXI_AWID    = aw_id;
  assign M1_AXI_AWLEN   = aw_len;
  assign M1_AXI_AWSIZE  = aw_size;
  assign M1_AXI_AWBURST = aw_burst;

  // W payload is not buffered; it flows straight to both ports.
  assign M0_AXI_WDATA = S_AXI_WDATA;
  assign M0_AXI_WSTRB = S_AXI_WSTRB;
  assign M0_AXI_WLAST = S_AXI_WLAST;
  assign M1_AXI_WDATA = S_AXI_WDATA;
  assign M1_AXI_WSTRB = S_AXI_WSTRB;
  assign M1_AXI_WLAST = S_AXI_WLAST;

endmodule

// File: tb/tb_axi_clint_xbar.sv
module tb_axi_clint_xbar;

  logic        clock = 1'b0;
  logic        S_AXI_ARESETN;

  logic [31:0] S_AXI_ARADDR;  logic [3:0] S_AXI_ARID;  logic [7:0] S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;  logic [1:0] S_AXI_ARBURST; logic S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;   logic [1:0] S_AXI_RRESP;   logic [3:0] S_AXI_RID;
  logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_AWADDR;  logic [3:0] S_AXI_AWID;  logic [7:0] S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;  logic [1:0] S_AXI_AWBURST; logic S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;   logic [3:0] S_AXI_WSTRB;
  logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;   logic [3:0] S_AXI_BID;   logic S_AXI_BVALID, S_AXI_BREADY;

  logic [31:0] M0_AXI_ARADDR; logic [3:0] M0_AXI_ARID; logic [7:0] M0_AXI_ARLEN;
  logic [2:0]  M0_AXI_ARSIZE; logic [1:0] M0_AXI_ARBURST; logic M0_AXI_ARVALID, M0_AXI_ARREADY;
  logic [31:0] M0_AXI_RDATA;  logic [1:0] M0_AXI_RRESP;  logic [3:0] M0_AXI_RID;
  logic        M0_AXI_RLAST, M0_AXI_RVALID, M0_AXI_RREADY;
  logic [31:0] M0_AXI_AWADDR; logic [3:0] M0_AXI_AWID; logic [7:0] M0_AXI_AWLEN;
  logic [2:0]  M0_AXI_AWSIZE; logic [1:0] M0_AXI_AWBURST; logic M0_AXI_AWVALID, M0_AXI_AWREADY;
  logic [31:0] M0_AXI_WDATA;  logic [3:0] M0_AXI_WSTRB;
  logic        M0_AXI_WLAST, M0_AXI_WVALID, M0_AXI_WREADY;
  logic [1:0]  M0_AXI_BRESP;  logic [3:0] M0_AXI_BID;  logic M0_AXI_BVALID, M0_AXI_BREADY;

  logic [31:0] M1_AXI_ARADDR; logic [3:0] M1_AXI_ARID; logic [7:0] M1_AXI_ARLEN;
  logic [2:0]  M1_AXI_ARSIZE; logic [1:0] M1_AXI_ARBURST; logic M1_AXI_ARVALID, M1_AXI_ARREADY;
  logic [31:0] M1_AXI_RDATA;  logic [1:0] M1_AXI_RRESP;  logic [3:0] M1_AXI_RID;
  logic        M1_AXI_RLAST, M1_AXI_RVALID, M1_AXI_RREADY;
  logic [31:0] M1_AXI_AWADDR; logic [3:0] M1_AXI_AWID; logic [7:0] M1_AXI_AWLEN;
  logic [2:0]  M1_AXI_AWSIZE; logic [1:0] M1_AXI_AWBURST; logic M1_AXI_AWVALID, M1_AXI_AWREADY;
  logic [31:0] M1_AXI_WDATA;  logic [3:0] M1_AXI_WSTRB;
  logic        M1_AXI_WLAST, M1_AXI_WVALID, M1_AXI_WREADY;
  logic [1:0]  M1_AXI_BRESP;  logic [3:0] M1_AXI_BID;  logic M1_AXI_BVALID, M1_AXI_BREADY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  axi_clint_xbar dut (
    .clock(clock), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RID(S_AXI_RID),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BID(S_AXI_BID), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .M0_AXI_ARADDR(M0_AXI_ARADDR), .M0_AXI_ARID(M0_AXI_ARID), .M0_AXI_ARLEN(M0_AXI_ARLEN),
    .M0_AXI_ARSIZE(M0_AXI_ARSIZE), .M0_AXI_ARBURST(M0_AXI_ARBURST),
    .M0_AXI_ARVALID(M0_AXI_ARVALID), .M0_AXI_ARREADY(M0_AXI_ARREADY),
    .M0_AXI_RDATA(M0_AXI_RDATA), .M0_AXI_RRESP(M0_AXI_RRESP), .M0_AXI_RID(M0_AXI_RID),
    .M0_AXI_RLAST(M0_AXI_RLAST), .M0_AXI_RVALID(M0_AXI_RVALID), .M0_AXI_RREADY(M0_AXI_RREADY),
    .M0_AXI_AWADDR(M0_AXI_AWADDR), .M0_AXI_AWID(M0_AXI_AWID), .M0_AXI_AWLEN(M0_AXI_AWLEN),
    .M0_AXI_AWSIZE(M0_AXI_AWSIZE), .M0_AXI_AWBURST(M0_AXI_AWBURST),
    .M0_AXI_AWVALID(M0_AXI_AWVALID), .M0_AXI_AWREADY(M0_AXI_AWREADY),
    .M0_AXI_WDATA(M0_AXI_WDATA), .M0_AXI_WSTRB(M0_AXI_WSTRB), .M0_AXI_WLAST(M0_AXI_WLAST),
    .M0_AXI_WVALID(M0_AXI_WVALID), .M0_AXI_WREADY(M0_AXI_WREADY),
    .M0_AXI_BRESP(M0_AXI_BRESP), .M0_AXI_BID(M0_AXI_BID), .M0_AXI_BVALID(M0_AXI_BVALID),
    .M0_AXI_BREADY(M0_AXI_BREADY),
    .M1_AXI_ARADDR(M1_AXI_ARADDR), .M1_AXI_ARID(M1_AXI_ARID), .M1_AXI_ARLEN(M1_AXI_ARLEN),
    .M1_AXI_ARSIZE(M1_AXI_ARSIZE), .M1_AXI_ARBURST(M1_AXI_ARBURST),
    .M1_AXI_ARVALID(M1_AXI_ARVALID), .M1_AXI_ARREADY(M1_AXI_ARREADY),
    .M1_AXI_RDATA(M1_AXI_RDATA), .M1_AXI_RRESP(M1_AXI_RRESP), .M1_AXI_RID(M1_AXI_RID),
    .M1_AXI_RLAST(M1_AXI_RLAST), .M1_AXI_RVALID(M1_AXI_RVALID), .M1_AXI_RREADY(M1_AXI_RREADY),
    .M1_AXI_AWADDR(M1_AXI_AWADDR), .M1_AXI_AWID(M1_AXI_AWID), .M1_AXI_AWLEN(M1_AXI_AWLEN),
    .M1_AXI_AWSIZE(M1_AXI_AWSIZE), .M1_AXI_AWBURST(M1_AXI_AWBURST),
    .M1_AXI_AWVALID(M1_AXI_AWVALID), .M1_AXI_AWREADY(M1_AXI_AWREADY),
    .M1_AXI_WDATA(M1_AXI_WDATA), .M1_AXI_WSTRB(M1_AXI_WSTRB), .M1_AXI_WLAST(M1_AXI_WLAST),
    .M1_AXI_WVALID(M1_AXI_WVALID), .M1_AXI_WREADY(M1_AXI_WREADY),
    .M1_AXI_BRESP(M1_AXI_BRESP), .M1_AXI_BID(M1_AXI_BID), .M1_AXI_BVALID(M1_AXI_BVALID),
    .M1_AXI_BREADY(M1_AXI_BREADY)
  );

  // Move to 1 ns after the next rising edge; inputs are driven and outputs
  // sampled between edges only.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic init_inputs();
    S_AXI_ARADDR = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd2;
    S_AXI_ARBURST = 2'd1; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = '0; S_AXI_AWID = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'd2;
    S_AXI_AWBURST = 2'd1; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    M0_AXI_ARREADY = 0; M0_AXI_RDATA = '0; M0_AXI_RRESP = '0; M0_AXI_RID = '0;
    M0_AXI_RLAST = 0; M0_AXI_RVALID = 0; M0_AXI_AWREADY = 0; M0_AXI_WREADY = 0;
    M0_AXI_BRESP = '0; M0_AXI_BID = '0; M0_AXI_BVALID = 0;
    M1_AXI_ARREADY = 0; M1_AXI_RDATA = '0; M1_AXI_RRESP = '0; M1_AXI_RID = '0;
    M1_AXI_RLAST = 0; M1_AXI_RVALID = 0; M1_AXI_AWREADY = 0; M1_AXI_WREADY = 0;
    M1_AXI_BRESP = '0; M1_AXI_BID = '0; M1_AXI_BVALID = 0;
  endtask

  task automatic test_reset();
    S_AXI_ARESETN = 0;
    init_inputs();
    tick(); tick();
    n_tests++;
    if ({M0_AXI_ARVALID, M0_AXI_AWVALID, M0_AXI_WVALID, M0_AXI_RREADY, M0_AXI_BREADY,
         M1_AXI_ARVALID, M1_AXI_AWVALID, M1_AXI_WVALID, M1_AXI_RREADY, M1_AXI_BREADY,
         S_AXI_RVALID, S_AXI_BVALID, S_AXI_WREADY} !== 13'b0) begin
      n_fail++; $display("FAIL reset_valids: got nonzero VALID/READY, expected all 0");
    end
    S_AXI_ARESETN = 1;
    tick();
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1 || S_AXI_AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: arready=%b awready=%b expected 1 1",
                         S_AXI_ARREADY, S_AXI_AWREADY);
    end
  endtask

  task automatic test_read_clint();
    S_AXI_ARADDR = 32'h0200_0000; S_AXI_ARID = 4'd3; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0;
    n_tests++;
    if (M0_AXI_ARVALID !== 1'b1 || M1_AXI_ARVALID !== 1'b0 || M0_AXI_ARADDR !== 32'h0200_0000) begin
      n_fail++; $display("FAIL rd_clint_ar: m0v=%b m1v=%b addr=%h expected 1 0 02000000",
                         M0_AXI_ARVALID, M1_AXI_ARVALID, M0_AXI_ARADDR);
    end
    M0_AXI_ARREADY = 1;
    tick();
    M0_AXI_ARREADY = 0;
    M0_AXI_RDATA = 32'hCAFE_F00D; M0_AXI_RID = 4'd0; M0_AXI_RLAST = 1; M0_AXI_RVALID = 1;
    S_AXI_RREADY = 1;
    #1;
    n_tests++;
    if (S_AXI_RDATA !== 32'hCAFE_F00D || S_AXI_RID !== 4'd3 || S_AXI_RLAST !== 1'b1 ||
        S_AXI_RVALID !== 1'b1 || M0_AXI_RREADY !== 1'b1 || M1_AXI_RREADY !== 1'b0) begin
      n_fail++; $display("FAIL rd_clint_r: data=%h id=%0d last=%b v=%b m0rr=%b m1rr=%b expected cafef00d 3 1 1 1 0",
                         S_AXI_RDATA, S_AXI_RID, S_AXI_RLAST, S_AXI_RVALID, M0_AXI_RREADY, M1_AXI_RREADY);
    end
    tick();
    M0_AXI_RVALID = 0; M0_AXI_RLAST = 0; S_AXI_RREADY = 0;
    #1;
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
      n_fail++; $display("FAIL rd_clint_idle: arready=%b rvalid=%b expected 1 0",
                         S_AXI_ARREADY, S_AXI_RVALID);
    end
  endtask

  task automatic test_burst_read_soc();
    S_AXI_ARADDR = 32'h8000_0000; S_AXI_ARID = 4'd6; S_AXI_ARLEN = 8'd3;
    S_AXI_ARBURST = 2'd1; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0;
    n_tests++;
    if (M1_AXI_ARVALID !== 1'b1 || M0_AXI_ARVALID !== 1'b0 || M1_AXI_ARLEN !== 8'd3) begin
      n_fail++; $display("FAIL burst_ar: m1v=%b m0v=%b len=%0d expected 1 0 3",
                         M1_AXI_ARVALID, M0_AXI_ARVALID, M1_AXI_ARLEN);
    end
    M1_AXI_ARREADY = 1;
    tick();
    M1_AXI_ARREADY = 0;
    S_AXI_RREADY = 1;
    for (int i = 0; i < 4; i++) begin
      M1_AXI_RDATA = 32'h1000 + i; M1_AXI_RLAST = (i == 3); M1_AXI_RVALID = 1;
      #1;
      n_tests++;
      if (S_AXI_RDATA !== 32'h1000 + i || S_AXI_RID !== 4'd6 || S_AXI_RVALID !== 1'b1 ||
          S_AXI_ARREADY !== 1'b0 || S_AXI_RLAST !== (i == 3)) begin
        n_fail++; $display("FAIL burst_beat%0d: data=%h id=%0d v=%b arready=%b last=%b expected %h 6 1 0 %b",
                           i, S_AXI_RDATA, S_AXI_RID, S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RLAST,
                           32'h1000 + i, (i == 3));
      end
      tick();
    end
    M1_AXI_RVALID = 0; M1_AXI_RLAST = 0; S_AXI_RREADY = 0;
    #1;
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL burst_done: arready=%b expected 1", S_AXI_ARREADY);
    end
  endtask

  task automatic test_write_clint();
    S_AXI_AWADDR = 32'h0200_0004; S_AXI_AWID = 4'd5; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1; S_AXI_WVALID = 1;
    #1;
    n_tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
      n_fail++; $display("FAIL wr_idle: awready=%b wready=%b expected 1 0", S_AXI_AWREADY, S_AXI_WREADY);
    end
    tick();
    S_AXI_AWVALID = 0;
    n_tests++;
    if (M0_AXI_AWVALID !== 1'b1 || M0_AXI_WVALID !== 1'b1 || M1_AXI_AWVALID !== 1'b0 ||
        M0_AXI_WDATA !== 32'h1234_5678 || M0_AXI_AWADDR !== 32'h0200_0004) begin
      n_fail++; $display("FAIL wr_fwd: awv=%b wv=%b m1awv=%b wdata=%h addr=%h expected 1 1 0 12345678 02000004",
                         M0_AXI_AWVALID, M0_AXI_WVALID, M1_AXI_AWVALID, M0_AXI_WDATA, M0_AXI_AWADDR);
    end
    M0_AXI_AWREADY = 1; M0_AXI_WREADY = 1;
    tick();
    M0_AXI_AWREADY = 0; M0_AXI_WREADY = 0; S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    M0_AXI_BRESP = 2'b10; M0_AXI_BID = 4'd0; M0_AXI_BVALID = 1; S_AXI_BREADY = 1;
    #1;
    n_tests++;
    if (M0_AXI_AWVALID !== 1'b0 || M0_AXI_WVALID !== 1'b0 || S_AXI_BVALID !== 1'b1 ||
        S_AXI_BID !== 4'd5 || S_AXI_BRESP !== 2'b10 || M0_AXI_BREADY !== 1'b1) begin
      n_fail++; $display("FAIL wr_resp: awv=%b wv=%b bv=%b bid=%0d bresp=%0d bready=%b expected 0 0 1 5 2 1",
                         M0_AXI_AWVALID, M0_AXI_WVALID, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, M0_AXI_BREADY);
    end
    tick();
    M0_AXI_BVALID = 0; S_AXI_BREADY = 0; M0_AXI_BRESP = 2'b00;
    #1;
    n_tests++;
    if (S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: awready=%b bvalid=%b expected 1 0", S_AXI_AWREADY, S_AXI_BVALID);
    end
  endtask

  task automatic test_back_pressure();
    S_AXI_ARADDR = 32'h0200_0008; S_AXI_ARID = 4'd1; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1;
    tick();
    M0_AXI_ARREADY = 1;
    S_AXI_ARADDR = 32'h8000_0040; S_AXI_ARID = 4'd7;   // competing request, held
    tick();
    M0_AXI_ARREADY = 0;
    M0_AXI_RDATA = 32'hA5A5_0001; M0_AXI_RLAST = 1; M0_AXI_RVALID = 1; S_AXI_RREADY = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hA5A5_0001 || M0_AXI_RREADY !== 1'b0 ||
          S_AXI_ARREADY !== 1'b0 || M0_AXI_ARVALID !== 1'b0 || M1_AXI_ARVALID !== 1'b0) begin
        n_fail++; $display("FAIL bp_stall%0d: rv=%b data=%h rr=%b arready=%b m0arv=%b m1arv=%b expected 1 a5a50001 0 0 0 0",
                           i, S_AXI_RVALID, S_AXI_RDATA, M0_AXI_RREADY, S_AXI_ARREADY,
                           M0_AXI_ARVALID, M1_AXI_ARVALID);
      end
      tick();
    end
    S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    #1;
    n_tests++;
    if (M0_AXI_RREADY !== 1'b1 || S_AXI_RID !== 4'd1) begin
      n_fail++; $display("FAIL bp_release: rr=%b rid=%0d expected 1 1", M0_AXI_RREADY, S_AXI_RID);
    end
    tick();
    M0_AXI_RVALID = 0; M0_AXI_RLAST = 0; S_AXI_RREADY = 0;
    #1;
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL bp_done: arready=%b expected 1", S_AXI_ARREADY);
    end
  endtask

  task automatic test_concurrent_decode_edge();
    S_AXI_ARADDR = 32'h0201_0000; S_AXI_ARID = 4'd9; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1;
    S_AXI_AWADDR = 32'h0200_FFFF; S_AXI_AWID = 4'hA; S_AXI_AWVALID = 1;
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'h3; S_AXI_WLAST = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_ARVALID = 0; S_AXI_AWVALID = 0;
    n_tests++;
    if (M1_AXI_ARVALID !== 1'b1 || M0_AXI_ARVALID !== 1'b0 || M0_AXI_AWVALID !== 1'b1 ||
        M1_AXI_AWVALID !== 1'b0 || M0_AXI_WVALID !== 1'b1 || M1_AXI_WVALID !== 1'b0) begin
      n_fail++; $display("FAIL conc_route: m1arv=%b m0arv=%b m0awv=%b m1awv=%b m0wv=%b m1wv=%b expected 1 0 1 0 1 0",
                         M1_AXI_ARVALID, M0_AXI_ARVALID, M0_AXI_AWVALID, M1_AXI_AWVALID,
                         M0_AXI_WVALID, M1_AXI_WVALID);
    end
    M1_AXI_ARREADY = 1; M0_AXI_AWREADY = 1;      // AW accepted first, W stalls
    tick();
    M1_AXI_ARREADY = 0; M0_AXI_AWREADY = 0;
    n_tests++;
    if (M0_AXI_AWVALID !== 1'b0 || M0_AXI_WVALID !== 1'b1 || S_AXI_WREADY !== 1'b0) begin
      n_fail++; $display("FAIL conc_aw_first: awv=%b wv=%b wready=%b expected 0 1 0",
                         M0_AXI_AWVALID, M0_AXI_WVALID, S_AXI_WREADY);
    end
    M0_AXI_WREADY = 1;
    M1_AXI_RDATA = 32'h0BAD_0001; M1_AXI_RLAST = 1; M1_AXI_RVALID = 1; S_AXI_RREADY = 1;
    #1;
    n_tests++;
    if (S_AXI_RID !== 4'd9 || S_AXI_RDATA !== 32'h0BAD_0001 || S_AXI_RVALID !== 1'b1 ||
        S_AXI_WREADY !== 1'b1) begin
      n_fail++; $display("FAIL conc_r: rid=%0d data=%h rv=%b wready=%b expected 9 0bad0001 1 1",
                         S_AXI_RID, S_AXI_RDATA, S_AXI_RVALID, S_AXI_WREADY);
    end
    tick();
    M0_AXI_WREADY = 0; S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    M1_AXI_RVALID = 0; M1_AXI_RLAST = 0; S_AXI_RREADY = 0;
    M0_AXI_BRESP = 2'b00; M0_AXI_BVALID = 1; S_AXI_BREADY = 1;
    #1;
    n_tests++;
    if (S_AXI_BID !== 4'hA || S_AXI_BVALID !== 1'b1 || M1_AXI_BREADY !== 1'b0 ||
        M0_AXI_BREADY !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL conc_b: bid=%0d bv=%b m1br=%b m0br=%b arready=%b expected 10 1 0 1 1",
                         S_AXI_BID, S_AXI_BVALID, M1_AXI_BREADY, M0_AXI_BREADY, S_AXI_ARREADY);
    end
    tick();
    M0_AXI_BVALID = 0; S_AXI_BREADY = 0;
    #1;
    n_tests++;
    if (S_AXI_AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL conc_done: awready=%b expected 1", S_AXI_AWREADY);
    end
  endtask

  task automatic test_decode_below();
    S_AXI_ARADDR = 32'h01FF_FFFC; S_AXI_ARID = 4'd2; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0;
    n_tests++;
    if (M1_AXI_ARVALID !== 1'b1 || M0_AXI_ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL decode_below: m1arv=%b m0arv=%b expected 1 0", M1_AXI_ARVALID, M0_AXI_ARVALID);
    end
    M1_AXI_ARREADY = 1;
    tick();
    M1_AXI_ARREADY = 0;
    M1_AXI_RLAST = 1; M1_AXI_RVALID = 1; S_AXI_RREADY = 1;
    tick();
    M1_AXI_RVALID = 0; M1_AXI_RLAST = 0; S_AXI_RREADY = 0;
  endtask

  task automatic test_reset_mid_burst();
    S_AXI_ARADDR = 32'h8000_1000; S_AXI_ARID = 4'd2; S_AXI_ARLEN = 8'd3; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0; M1_AXI_ARREADY = 1;
    tick();
    M1_AXI_ARREADY = 0;
    M1_AXI_RDATA = 32'h2000; M1_AXI_RVALID = 1; S_AXI_RREADY = 1;
    tick();                                      // first beat taken
    M1_AXI_RDATA = 32'h2001;
    S_AXI_ARESETN = 0;
    #1;
    n_tests++;
    if (S_AXI_RVALID !== 1'b0 || M1_AXI_RREADY !== 1'b0 || M1_AXI_ARVALID !== 1'b0 ||
        M0_AXI_ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: rv=%b m1rr=%b m1arv=%b m0arv=%b expected 0 0 0 0",
                         S_AXI_RVALID, M1_AXI_RREADY, M1_AXI_ARVALID, M0_AXI_ARVALID);
    end
    M1_AXI_RVALID = 0; S_AXI_RREADY = 0;
    tick();
    S_AXI_ARESETN = 1;
    tick();
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1 || S_AXI_AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL rst_release: arready=%b awready=%b expected 1 1",
                         S_AXI_ARREADY, S_AXI_AWREADY);
    end
    S_AXI_ARADDR = 32'h0200_0010; S_AXI_ARID = 4'd4; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0; M0_AXI_ARREADY = 1;
    tick();
    M0_AXI_ARREADY = 0;
    M0_AXI_RDATA = 32'h0000_BEEF; M0_AXI_RLAST = 1; M0_AXI_RVALID = 1; S_AXI_RREADY = 1;
    #1;
    n_tests++;
    if (S_AXI_RID !== 4'd4 || S_AXI_RDATA !== 32'h0000_BEEF || S_AXI_RVALID !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh_read: rid=%0d data=%h rv=%b expected 4 0000beef 1",
                         S_AXI_RID, S_AXI_RDATA, S_AXI_RVALID);
    end
    tick();
    M0_AXI_RVALID = 0; M0_AXI_RLAST = 0; S_AXI_RREADY = 0;
    #1;
    n_tests++;
    if (S_AXI_ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL rst_fresh_done: arready=%b expected 1", S_AXI_ARREADY);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_clint();
    test_burst_read_soc();
    test_write_clint();
    test_back_pressure();
    test_concurrent_decode_edge();
    test_decode_below();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
